// File: rtl/pipeline_mem_stage.sv
// Memory-access stage of the RV64 pipeline.
//
// Takes the EXA pipeline register (effective address, load/store controls,
// store data, writeback controls), runs one request/acknowledge transaction
// on a 64-bit data bus with byte strobes, aligns and extends load data, and
// registers the outcome into the MEM/WB pipeline register.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   flush, stall      hazard-unit controls
//   *_EXA             inputs from the EXA pipeline register
//   mem_*             data-memory bus (req/we/addr/wdata/wstrb out, ack/rdata in)
//   mem_busy          combinational stall request to the hazard unit
//   *_MEM             MEM/WB pipeline register outputs
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no transaction open; a valid access issues combinationally
// BUSY   | request open, waiting for ack (or timeout)
// HOLD   | ack received while stalled; result buffered, no re-issue
// DRAIN  | instruction flushed mid-transaction; finish the bus cycle, discard
module pipeline_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic [63:0] pc_EXA,
  input  logic        rf_wr_en_EXA,
  input  logic [1:0]  rf_wr_sel_EXA,
  input  logic [63:0] alu_result_EXA,
  input  logic [2:0]  dm_rd_ctrl_EXA,
  input  logic [2:0]  dm_wr_ctrl_EXA,
  input  logic [63:0] reg_data2_EXA,
  input  logic [4:0]  rd_EXA,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        mem_busy,
  output logic [63:0] pc_MEM,
  output logic        rf_wr_en_MEM,
  output logic [1:0]  rf_wr_sel_MEM,
  output logic [63:0] alu_result_MEM,
  output logic [63:0] dm_rdata_MEM,
  output logic [4:0]  rd_MEM,
  output logic        misalign_MEM,
  output logic        bus_err_MEM
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // request fields latched at issue so the bus stays stable even after a
  // flush has replaced the EXA contents
  logic [63:0] req_addr_q, req_addr_d;
  logic        req_we_q, req_we_d;
  logic [63:0] req_wdata_q, req_wdata_d;
  logic [7:0]  req_wstrb_q, req_wstrb_d;

  logic [63:0] hold_data_q, hold_data_d;
  logic        hold_err_q, hold_err_d;

  logic [63:0] pc_mem_q, pc_mem_d;
  logic        rf_wr_en_mem_q, rf_wr_en_mem_d;
  logic [1:0]  rf_wr_sel_mem_q, rf_wr_sel_mem_d;
  logic [63:0] alu_result_mem_q, alu_result_mem_d;
  logic [63:0] dm_rdata_mem_q, dm_rdata_mem_d;
  logic [4:0]  rd_mem_q, rd_mem_d;
  logic        misalign_mem_q, misalign_mem_d;
  logic        bus_err_mem_q, bus_err_mem_d;

  // ---------------------------------------------------------------- decode
  logic [2:0]  off;
  logic        is_store, is_load, misaligned, op_valid;
  logic [1:0]  acc_size;
  logic [63:0] st_wdata;
  logic [7:0]  st_wstrb;
  logic [63:0] lane;
  logic [63:0] ld_data;

  always_comb begin
    off      = alu_result_EXA[2:0];
    is_store = (dm_wr_ctrl_EXA != 3'd0) && (dm_wr_ctrl_EXA <= 3'd4);
    is_load  = (dm_rd_ctrl_EXA != 3'd0) && !is_store;
    acc_size = 2'd0;
    if (is_store) begin
      case (dm_wr_ctrl_EXA)
        3'd2:    acc_size = 2'd1;
        3'd3:    acc_size = 2'd2;
        3'd4:    acc_size = 2'd3;
        default: acc_size = 2'd0;
      endcase
    end else if (is_load) begin
      case (dm_rd_ctrl_EXA)
        3'd3, 3'd4: acc_size = 2'd1;
        3'd5, 3'd6: acc_size = 2'd2;
        3'd7:       acc_size = 2'd3;
        default:    acc_size = 2'd0;
      endcase
    end
    misaligned = (is_store || is_load) &&
                 (((acc_size == 2'd1) && off[0]) ||
                  ((acc_size == 2'd2) && (off[1:0] != 2'd0)) ||
                  ((acc_size == 2'd3) && (off != 3'd0)));
    op_valid   = (is_store || is_load) && !misaligned;
  end

  always_comb begin
    st_wdata = reg_data2_EXA;
    st_wstrb = 8'h00;
    case (dm_wr_ctrl_EXA)
      3'd1: begin
        st_wdata = {8{reg_data2_EXA[7:0]}};
        st_wstrb = 8'h01 << off;
      end
      3'd2: begin
        st_wdata = {4{reg_data2_EXA[15:0]}};
        st_wstrb = 8'h03 << off;
      end
      3'd3: begin
        st_wdata = {2{reg_data2_EXA[31:0]}};
        st_wstrb = 8'h0F << off;
      end
      3'd4: begin
        st_wdata = reg_data2_EXA;
        st_wstrb = 8'hFF;
      end
      default: begin
        st_wdata = reg_data2_EXA;
        st_wstrb = 8'h00;
      end
    endcase
  end

  always_comb begin
    lane    = mem_rdata >> {off, 3'b000};
    ld_data = 64'd0;
    if (is_load) begin
      case (dm_rd_ctrl_EXA)
        3'd1:    ld_data = {{56{lane[7]}}, lane[7:0]};
        3'd2:    ld_data = {56'd0, lane[7:0]};
        3'd3:    ld_data = {{48{lane[15]}}, lane[15:0]};
        3'd4:    ld_data = {48'd0, lane[15:0]};
        3'd5:    ld_data = {{32{lane[31]}}, lane[31:0]};
        3'd6:    ld_data = {32'd0, lane[31:0]};
        3'd7:    ld_data = lane;
        default: ld_data = 64'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  logic timeout_hit, done;
  logic req_int, we_int;
  logic [63:0] addr_int, wdata_int;
  logic [7:0]  wstrb_int;

  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) &&
                  ((state_q == S_BUSY) || (state_q == S_DRAIN)) &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES));
    // a timeout completes the transaction just like an ack
    done        = mem_ack || timeout_hit;
  end

  always_comb begin
    state_d   = state_q;
    req_int   = 1'b0;
    we_int    = 1'b0;
    addr_int  = req_addr_q;
    wdata_int = req_wdata_q;
    wstrb_int = 8'h00;
    case (state_q)
      S_IDLE: begin
        req_int   = op_valid;
        we_int    = op_valid && is_store;
        addr_int  = {alu_result_EXA[63:3], 3'b000};
        wdata_int = st_wdata;
        wstrb_int = (op_valid && is_store) ? st_wstrb : 8'h00;
        if (op_valid) begin
          if (mem_ack) begin
            state_d = (stall && !flush) ? S_HOLD : S_IDLE;
          end else begin
            // the request is already on the bus; a flush must still drain it
            state_d = flush ? S_DRAIN : S_BUSY;
          end
        end
      end
      S_BUSY: begin
        req_int   = !timeout_hit;
        we_int    = req_we_q && !timeout_hit;
        wstrb_int = timeout_hit ? 8'h00 : req_wstrb_q;
        if (done) begin
          state_d = (stall && !flush) ? S_HOLD : S_IDLE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (flush || !stall) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        req_int   = !timeout_hit;
        we_int    = req_we_q && !timeout_hit;
        wstrb_int = timeout_hit ? 8'h00 : req_wstrb_q;
        if (done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // counter runs only while staying in a waiting state; any transition clears it
    cnt_d = '0;
    if (((state_q == S_BUSY) || (state_q == S_DRAIN)) && (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end

    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    if ((state_q == S_IDLE) && op_valid) begin
      req_addr_d  = addr_int;
      req_we_d    = we_int;
      req_wdata_d = wdata_int;
      req_wstrb_d = wstrb_int;
    end

    hold_data_d = hold_data_q;
    hold_err_d  = hold_err_q;
    if ((state_q != S_HOLD) && (state_d == S_HOLD)) begin
      hold_data_d = timeout_hit ? 64'd0 : ld_data;
      hold_err_d  = timeout_hit;
    end
  end

  always_comb begin
    mem_busy = (op_valid && ((state_q == S_IDLE) || (state_q == S_BUSY)) && !done) ||
               (state_q == S_DRAIN);
    // bus controls stay quiet while reset is asserted, regardless of EXA inputs
    mem_req   = req_int && reset;
    mem_we    = we_int && reset;
    mem_wstrb = reset ? wstrb_int : 8'h00;
    mem_addr  = addr_int;
    mem_wdata = wdata_int;
  end

  // ---------------------------------------------------------------- MEM/WB
  logic [63:0] cap_rdata;
  logic        cap_err;

  always_comb begin
    cap_rdata = (is_load && op_valid) ? ld_data : 64'd0;
    cap_err   = 1'b0;
    if (state_q == S_HOLD) begin
      cap_rdata = hold_data_q;
      cap_err   = hold_err_q;
    end else if ((state_q == S_BUSY) && timeout_hit) begin
      cap_rdata = 64'd0;
      cap_err   = 1'b1;
    end

    pc_mem_d         = pc_mem_q;
    rf_wr_en_mem_d   = rf_wr_en_mem_q;
    rf_wr_sel_mem_d  = rf_wr_sel_mem_q;
    alu_result_mem_d = alu_result_mem_q;
    dm_rdata_mem_d   = dm_rdata_mem_q;
    rd_mem_d         = rd_mem_q;
    misalign_mem_d   = misalign_mem_q;
    bus_err_mem_d    = bus_err_mem_q;

    if (flush || (!stall && mem_busy)) begin
      pc_mem_d         = 64'd0;
      rf_wr_en_mem_d   = 1'b0;
      rf_wr_sel_mem_d  = 2'd0;
      alu_result_mem_d = 64'd0;
      dm_rdata_mem_d   = 64'd0;
      rd_mem_d         = 5'd0;
      misalign_mem_d   = 1'b0;
      bus_err_mem_d    = 1'b0;
    end else if (!stall) begin
      pc_mem_d         = pc_EXA;
      rf_wr_en_mem_d   = rf_wr_en_EXA && !misaligned && !cap_err;
      rf_wr_sel_mem_d  = rf_wr_sel_EXA;
      alu_result_mem_d = alu_result_EXA;
      dm_rdata_mem_d   = cap_rdata;
      rd_mem_d         = rd_EXA;
      misalign_mem_d   = misaligned;
      bus_err_mem_d    = cap_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      req_addr_q       <= 64'd0;
      req_we_q         <= 1'b0;
      req_wdata_q      <= 64'd0;
      req_wstrb_q      <= 8'h00;
      hold_data_q      <= 64'd0;
      hold_err_q       <= 1'b0;
      pc_mem_q         <= 64'd0;
      rf_wr_en_mem_q   <= 1'b0;
      rf_wr_sel_mem_q  <= 2'd0;
      alu_result_mem_q <= 64'd0;
      dm_rdata_mem_q   <= 64'd0;
      rd_mem_q         <= 5'd0;
      misalign_mem_q   <= 1'b0;
      bus_err_mem_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      req_addr_q       <= req_addr_d;
      req_we_q         <= req_we_d;
      req_wdata_q      <= req_wdata_d;
      req_wstrb_q      <= req_wstrb_d;
      hold_data_q      <= hold_data_d;
      hold_err_q       <= hold_err_d;
      pc_mem_q         <= pc_mem_d;
      rf_wr_en_mem_q   <= rf_wr_en_mem_d;
      rf_wr_sel_mem_q  <= rf_wr_sel_mem_d;
      alu_result_mem_q <= alu_result_mem_d;
      dm_rdata_mem_q   <= dm_rdata_mem_d;
      rd_mem_q         <= rd_mem_d;
      misalign_mem_q   <= misalign_mem_d;
      bus_err_mem_q    <= bus_err_mem_d;
    end
  end

  assign pc_MEM         = pc_mem_q;
  assign rf_wr_en_MEM   = rf_wr_en_mem_q;
  assign rf_wr_sel_MEM  = rf_wr_sel_mem_q;
  assign alu_result_MEM = alu_result_mem_q;
  assign dm_rdata_MEM   = dm_rdata_mem_q;
  assign rd_MEM         = rd_mem_q;
  assign misalign_MEM   = misalign_mem_q;
  assign bus_err_MEM    = bus_err_mem_q;

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// Directed bench for pipeline_mem_stage: loads/stores with zero-wait and
// delayed acks, misalignment, flush into DRAIN, stall into HOLD, bus timeout
// and reset in the middle of a transaction.
module tb_pipeline_mem_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        stall;
  logic [63:0] pc_EXA;
  logic        rf_wr_en_EXA;
  logic [1:0]  rf_wr_sel_EXA;
  logic [63:0] alu_result_EXA;
  logic [2:0]  dm_rd_ctrl_EXA;
  logic [2:0]  dm_wr_ctrl_EXA;
  logic [63:0] reg_data2_EXA;
  logic [4:0]  rd_EXA;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        mem_busy;
  logic [63:0] pc_MEM;
  logic        rf_wr_en_MEM;
  logic [1:0]  rf_wr_sel_MEM;
  logic [63:0] alu_result_MEM;
  logic [63:0] dm_rdata_MEM;
  logic [4:0]  rd_MEM;
  logic        misalign_MEM;
  logic        bus_err_MEM;

  int checks = 0;
  int errors = 0;

  pipeline_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .pc_EXA(pc_EXA), .rf_wr_en_EXA(rf_wr_en_EXA), .rf_wr_sel_EXA(rf_wr_sel_EXA),
    .alu_result_EXA(alu_result_EXA), .dm_rd_ctrl_EXA(dm_rd_ctrl_EXA),
    .dm_wr_ctrl_EXA(dm_wr_ctrl_EXA), .reg_data2_EXA(reg_data2_EXA), .rd_EXA(rd_EXA),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .pc_MEM(pc_MEM), .rf_wr_en_MEM(rf_wr_en_MEM), .rf_wr_sel_MEM(rf_wr_sel_MEM),
    .alu_result_MEM(alu_result_MEM), .dm_rdata_MEM(dm_rdata_MEM), .rd_MEM(rd_MEM),
    .misalign_MEM(misalign_MEM), .bus_err_MEM(bus_err_MEM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance to just after the next active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [63:0] pc, input logic wr_en, input logic [1:0] sel,
                        input logic [63:0] alu, input logic [2:0] rdc, input logic [2:0] wrc,
                        input logic [63:0] d2, input logic [4:0] rd);
    pc_EXA         = pc;
    rf_wr_en_EXA   = wr_en;
    rf_wr_sel_EXA  = sel;
    alu_result_EXA = alu;
    dm_rd_ctrl_EXA = rdc;
    dm_wr_ctrl_EXA = wrc;
    reg_data2_EXA  = d2;
    rd_EXA         = rd;
    #1;
  endtask

  task automatic set_nop();
    set_op(64'd0, 1'b0, 2'd0, 64'd0, 3'd0, 3'd0, 64'd0, 5'd0);
  endtask

  // store lane replication vectors: {ctrl, addr, data, exp_wdata, exp_wstrb}
  logic [2:0]  st_ctrl [4];
  logic [63:0] st_addr [4];
  logic [63:0] st_data [4];
  logic [63:0] st_expd [4];
  logic [7:0]  st_exps [4];

  initial begin
    st_ctrl[0] = 3'd1; st_addr[0] = 64'h5005; st_data[0] = 64'h00000000_000000AB;
    st_expd[0] = 64'hABABABAB_ABABABAB; st_exps[0] = 8'h20;
    st_ctrl[1] = 3'd2; st_addr[1] = 64'h2006; st_data[1] = 64'h00000000_00001234;
    st_expd[1] = 64'h12341234_12341234; st_exps[1] = 8'hC0;
    st_ctrl[2] = 3'd3; st_addr[2] = 64'h5004; st_data[2] = 64'h00000000_DEADBEEF;
    st_expd[2] = 64'hDEADBEEF_DEADBEEF; st_exps[2] = 8'hF0;
    st_ctrl[3] = 3'd4; st_addr[3] = 64'h5008; st_data[3] = 64'h01234567_89ABCDEF;
    st_expd[3] = 64'h01234567_89ABCDEF; st_exps[3] = 8'hFF;

    reset = 1'b0; flush = 1'b0; stall = 1'b0; mem_ack = 1'b0; mem_rdata = 64'd0;
    set_nop();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_pc", pc_MEM, 64'd0);
    check_val("rst_wen", {63'd0, rf_wr_en_MEM}, 64'd0);
    check_val("rst_req", {63'd0, mem_req}, 64'd0);
    check_val("rst_strb", {56'd0, mem_wstrb}, 64'd0);
    reset = 1'b1;
    tick();

    // LB, zero-wait
    set_op(64'h100, 1'b1, 2'd1, 64'h1003, 3'd1, 3'd0, 64'd0, 5'd3);
    mem_rdata = 64'h00000000_80000000; mem_ack = 1'b1; #1;
    check_val("lb_req", {63'd0, mem_req}, 64'd1);
    check_val("lb_addr", mem_addr, 64'h1000);
    check_val("lb_strb", {56'd0, mem_wstrb}, 64'd0);
    check_val("lb_busy", {63'd0, mem_busy}, 64'd0);
    tick();
    check_val("lb_data", dm_rdata_MEM, 64'hFFFFFFFF_FFFFFF80);
    check_val("lb_wen", {63'd0, rf_wr_en_MEM}, 64'd1);
    check_val("lb_rd", {59'd0, rd_MEM}, 64'd3);
    check_val("lb_pc", pc_MEM, 64'h100);
    check_val("lb_sel", {62'd0, rf_wr_sel_MEM}, 64'd1);

    // store strobe / replication table, zero-wait
    for (int i = 0; i < 4; i++) begin
      set_op(64'h200 + 64'(i), 1'b1, 2'd0, st_addr[i], 3'd0, st_ctrl[i], st_data[i], 5'd4);
      check_val("st_we", {63'd0, mem_we}, 64'd1);
      check_val("st_wdata", mem_wdata, st_expd[i]);
      check_val("st_wstrb", {56'd0, mem_wstrb}, {56'd0, st_exps[i]});
      tick();
      check_val("st_wen", {63'd0, rf_wr_en_MEM}, 64'd1);
      check_val("st_mis", {63'd0, misalign_MEM}, 64'd0);
      check_val("st_rdata", dm_rdata_MEM, 64'd0);
    end

    // store wins over load when both encoded
    set_op(64'h210, 1'b0, 2'd0, 64'h6000, 3'd7, 3'd4, 64'h55, 5'd0);
    check_val("both_we", {63'd0, mem_we}, 64'd1);
    tick();
    check_val("both_rdata", dm_rdata_MEM, 64'd0);

    // LHU zero-extend at off=2
    set_op(64'h220, 1'b1, 2'd1, 64'h5002, 3'd4, 3'd0, 64'd0, 5'd6);
    mem_rdata = 64'h00000000_87654321; #1;
    tick();
    check_val("lhu_data", dm_rdata_MEM, 64'h00000000_00008765);

    // LW at off=4 with 3 wait cycles
    set_op(64'h300, 1'b1, 2'd1, 64'h3004, 3'd5, 3'd0, 64'd0, 5'd8);
    mem_rdata = 64'h80000001_00000000; mem_ack = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check_val("lw_busy", {63'd0, mem_busy}, 64'd1);
      check_val("lw_addr", mem_addr, 64'h3000);
      tick();
      check_val("lw_bubble", {63'd0, rf_wr_en_MEM}, 64'd0);
      check_val("lw_bub_rd", {59'd0, rd_MEM}, 64'd0);
    end
    mem_ack = 1'b1; #1;
    check_val("lw_busy_ack", {63'd0, mem_busy}, 64'd0);
    tick();
    mem_ack = 1'b0;
    check_val("lw_data", dm_rdata_MEM, 64'hFFFFFFFF_80000001);
    check_val("lw_wen", {63'd0, rf_wr_en_MEM}, 64'd1);
    check_val("lw_rd", {59'd0, rd_MEM}, 64'd8);

    // misaligned LD
    set_op(64'h400, 1'b1, 2'd1, 64'h4004, 3'd7, 3'd0, 64'd0, 5'd9);
    check_val("mis_req", {63'd0, mem_req}, 64'd0);
    check_val("mis_busy", {63'd0, mem_busy}, 64'd0);
    tick();
    check_val("mis_flag", {63'd0, misalign_MEM}, 64'd1);
    check_val("mis_wen", {63'd0, rf_wr_en_MEM}, 64'd0);
    check_val("mis_alu", alu_result_MEM, 64'h4004);

    // flush while BUSY -> DRAIN, transaction completes, no writeback
    set_op(64'h500, 1'b1, 2'd1, 64'h6000, 3'd5, 3'd0, 64'd0, 5'd7);
    tick();
    flush = 1'b1; #1;
    check_val("fl_req_busy", {63'd0, mem_req}, 64'd1);
    tick();
    flush = 1'b0;
    set_op(64'h504, 1'b1, 2'd0, 64'h99, 3'd0, 3'd0, 64'd0, 5'd9);
    check_val("fl_wen0", {63'd0, rf_wr_en_MEM}, 64'd0);
    check_val("dr_req", {63'd0, mem_req}, 64'd1);
    check_val("dr_addr", mem_addr, 64'h6000);
    check_val("dr_busy", {63'd0, mem_busy}, 64'd1);
    tick();
    check_val("dr_wen", {63'd0, rf_wr_en_MEM}, 64'd0);
    mem_ack = 1'b1; #1;
    check_val("dr_busy_ack", {63'd0, mem_busy}, 64'd1);
    tick();
    mem_ack = 1'b0; #1;
    check_val("dr_wen_ack", {63'd0, rf_wr_en_MEM}, 64'd0);
    check_val("dr_idle_req", {63'd0, mem_req}, 64'd0);
    check_val("dr_idle_busy", {63'd0, mem_busy}, 64'd0);
    tick();
    check_val("dr_next_rd", {59'd0, rd_MEM}, 64'd9);
    check_val("dr_next_wen", {63'd0, rf_wr_en_MEM}, 64'd1);

    // stall at ack -> HOLD, single request, capture when stall drops
    set_op(64'h600, 1'b1, 2'd1, 64'h7000, 3'd5, 3'd0, 64'd0, 5'd11);
    mem_rdata = 64'h00000000_11223344; #1;
    tick();
    mem_ack = 1'b1; stall = 1'b1; #1;
    check_val("hd_req_ack", {63'd0, mem_req}, 64'd1);
    tick();
    mem_ack = 1'b0; mem_rdata = 64'hDEADDEAD_DEADDEAD; #1;
    check_val("hd_req0", {63'd0, mem_req}, 64'd0);
    check_val("hd_busy", {63'd0, mem_busy}, 64'd0);
    tick();
    check_val("hd_held", {63'd0, rf_wr_en_MEM}, 64'd0);
    stall = 1'b0; #1;
    check_val("hd_req1", {63'd0, mem_req}, 64'd0);
    tick();
    set_nop();
    check_val("hd_data", dm_rdata_MEM, 64'h00000000_11223344);
    check_val("hd_wen", {63'd0, rf_wr_en_MEM}, 64'd1);
    check_val("hd_rd", {59'd0, rd_MEM}, 64'd11);

    // timeout after 4 BUSY cycles
    set_op(64'h700, 1'b1, 2'd1, 64'h8000, 3'd7, 3'd0, 64'd0, 5'd12);
    mem_rdata = 64'hFFFFFFFF_FFFFFFFF; #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("to_req_hi", {63'd0, mem_req}, 64'd1);
    end
    tick();
    check_val("to_req_lo", {63'd0, mem_req}, 64'd0);
    tick();
    set_nop();
    check_val("to_err", {63'd0, bus_err_MEM}, 64'd1);
    check_val("to_data", dm_rdata_MEM, 64'd0);
    check_val("to_wen", {63'd0, rf_wr_en_MEM}, 64'd0);

    // reset mid-transaction
    set_op(64'h800, 1'b1, 2'd1, 64'h9000, 3'd5, 3'd0, 64'd0, 5'd13);
    tick();
    check_val("mr_req_pre", {63'd0, mem_req}, 64'd1);
    reset = 1'b0; #1;
    check_val("mr_req", {63'd0, mem_req}, 64'd0);
    check_val("mr_err", {63'd0, bus_err_MEM}, 64'd0);
    set_nop();
    tick();
    reset = 1'b1; #1;
    check_val("mr_busy", {63'd0, mem_busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
